sdram_read: RTL and testbench

Full-page-mode SDRAM read-burst controller, the read-side counterpart of `sdram_write`. On `rd_en` it opens the addressed row and issues a column READ. It terminates the burst after `rd_burst_len` words with BURST STOP, precharges all banks and pulses `rd_end`. It sits beside `sdram_init` and `sdram_write` behind the command arbiter and drives the shared command/address bus only while granted.

---
 rtl/sdram_pkg.sv | 41 ++++
 rtl/sdram_read.sv | 141 ++++++++++++++
 tb/tb_sdram_read.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, address slices and read FSM states
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_BSTOP     = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;

  localparam int BANK_MSB = 23;
  localparam int BANK_LSB = 22;
  localparam int ROW_MSB  = 21;
  localparam int ROW_LSB  = 9;
  localparam int COL_MSB  = 8;
  localparam int COL_LSB  = 0;

  localparam int MAX_BURST = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_TRCD,
    ST_READ,
    ST_DATA,
    ST_PRECHARGE,
    ST_TRP,
    ST_END
  } rd_state_t;

  // A zero-length request still reads one word; anything past a full page is clamped.
  function automatic logic [9:0] eff_burst_len(input logic [9:0] len);
    if (len == 10'd0)
      return 10'd1;
    else if (len > 10'(MAX_BURST))
      return 10'(MAX_BURST);
    else
      return len;
  endfunction

endpackage

// File: rtl/sdram_read.sv
// rtl/sdram_read.sv - full-page SDRAM read-burst controller (ACTIVE, READ, BURST STOP, PRECHARGE)
// Optional DQ capture register selected by SDRAM_READ_DQ_REG_EN.
module sdram_read
  import sdram_pkg::*;
#(
  parameter int T_RCD       = 2,
  parameter int CAS_LATENCY = 3,
  parameter int T_RP        = 2
) (
  input  logic        clk_100M,
  input  logic        locked_rst_n,
  input  logic        rd_en,
  input  logic [23:0] rd_addr,
  input  logic [9:0]  rd_burst_len,
  input  logic [15:0] rd_sdram_data,
  output logic [3:0]  rd_cmd,
  output logic [1:0]  rd_bank_addr,
  output logic [12:0] rd_sdram_addr,
  output logic [15:0] rd_data,
  output logic        rd_ack,
  output logic        rd_end
);

`ifdef SDRAM_READ_DQ_REG_EN
  localparam int DQ_LAT = CAS_LATENCY + 1;
`else
  localparam int DQ_LAT = CAS_LATENCY;
`endif

  rd_state_t   state, state_nxt;
  logic [10:0] cnt, cnt_nxt;
  logic [1:0]  bank_q;
  logic [12:0] row_q;
  logic [8:0]  col_q;
  logic [9:0]  len_q;
  logic        last_ack;

  // cnt is 0 in the READ cycle, so cnt == DQ_LAT marks the first valid word
  assign last_ack = (cnt == 11'(DQ_LAT) + 11'(len_q) - 11'd1);

  always_ff @(posedge clk_100M or negedge locked_rst_n) begin
    if (!locked_rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      bank_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
      len_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == ST_IDLE && rd_en) begin
        bank_q <= rd_addr[BANK_MSB:BANK_LSB];
        row_q  <= rd_addr[ROW_MSB:ROW_LSB];
        col_q  <= rd_addr[COL_MSB:COL_LSB];
        len_q  <= eff_burst_len(rd_burst_len);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rd_cmd        = CMD_NOP;
    rd_bank_addr  = '0;
    rd_sdram_addr = '0;
    rd_ack        = 1'b0;
    rd_end        = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (rd_en) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        rd_cmd        = CMD_ACTIVE;
        rd_bank_addr  = bank_q;
        rd_sdram_addr = row_q;
        cnt_nxt       = '0;
        state_nxt     = (T_RCD > 1) ? ST_TRCD : ST_READ;
      end
      ST_TRCD: begin
        if (cnt == 11'(T_RCD - 2)) begin
          cnt_nxt   = '0;
          state_nxt = ST_READ;
        end else begin
          cnt_nxt = cnt + 11'd1;
        end
      end
      ST_READ: begin
        rd_cmd        = CMD_READ;
        rd_bank_addr  = bank_q;
        rd_sdram_addr = {4'b0000, col_q};
        cnt_nxt       = cnt + 11'd1;
        state_nxt     = ST_DATA;
      end
      ST_DATA: begin
        if (cnt == {1'b0, len_q}) rd_cmd = CMD_BSTOP;
        rd_ack = (cnt >= 11'(DQ_LAT));
        if (last_ack) begin
          cnt_nxt   = '0;
          state_nxt = ST_PRECHARGE;
        end else begin
          cnt_nxt = cnt + 11'd1;
        end
      end
      ST_PRECHARGE: begin
        rd_cmd        = CMD_PRECHARGE;
        rd_sdram_addr = 13'h0400;
        cnt_nxt       = '0;
        state_nxt     = (T_RP > 1) ? ST_TRP : ST_END;
      end
      ST_TRP: begin
        if (cnt == 11'(T_RP - 2)) begin
          cnt_nxt   = '0;
          state_nxt = ST_END;
        end else begin
          cnt_nxt = cnt + 11'd1;
        end
      end
      ST_END: begin
        rd_end    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef SDRAM_READ_DQ_REG_EN
  logic [15:0] dq_q;

  always_ff @(posedge clk_100M or negedge locked_rst_n) begin
    if (!locked_rst_n) dq_q <= '0;
    else               dq_q <= rd_sdram_data;
  end

  assign rd_data = dq_q;
`else
  assign rd_data = rd_sdram_data;
`endif

endmodule

// File: tb/tb_sdram_read.sv
// tb/tb_sdram_read.sv - scoreboard bench for sdram_read with a behavioural full-page SDRAM read model
module tb_sdram_read;
  import sdram_pkg::*;

  localparam int T_RCD = 2;
  localparam int CL    = 3;
  localparam int T_RP  = 2;
`ifdef SDRAM_READ_DQ_REG_EN
  localparam int LAT = CL + 1;
`else
  localparam int LAT = CL;
`endif

  logic        clk_100M      = 1'b0;
  logic        locked_rst_n  = 1'b0;
  logic        rd_en         = 1'b0;
  logic [23:0] rd_addr       = '0;
  logic [9:0]  rd_burst_len  = '0;
  logic [15:0] rd_sdram_data = 16'hdead;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_bank_addr;
  logic [12:0] rd_sdram_addr;
  logic [15:0] rd_data;
  logic        rd_ack;
  logic        rd_end;

  sdram_read #(.T_RCD(T_RCD), .CAS_LATENCY(CL), .T_RP(T_RP)) dut (
    .clk_100M     (clk_100M),
    .locked_rst_n (locked_rst_n),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_burst_len (rd_burst_len),
    .rd_sdram_data(rd_sdram_data),
    .rd_cmd       (rd_cmd),
    .rd_bank_addr (rd_bank_addr),
    .rd_sdram_addr(rd_sdram_addr),
    .rd_data      (rd_data),
    .rd_ack       (rd_ack),
    .rd_end       (rd_end)
  );

  always #5 clk_100M = ~clk_100M;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk_100M) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input logic [1:0] b, input logic [12:0] r, input logic [8:0] c);
    return {b, r[4:0], c};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // SDRAM model: words appear CL cycles after READ, last one CL-1 cycles after BURST STOP
  logic        m_burst = 1'b0;
  int          m_start = 0;
  int          m_stop  = 0;
  logic [1:0]  m_ba    = '0;
  logic [12:0] m_row   = '0;
  logic [8:0]  m_col   = '0;

  always @(posedge clk_100M) begin
    #1;
    if (!locked_rst_n) begin
      m_burst = 1'b0;
    end else begin
      case (rd_cmd)
        CMD_ACTIVE: begin m_ba = rd_bank_addr; m_row = rd_sdram_addr; end
        CMD_READ:   begin m_burst = 1'b1; m_start = cyc; m_stop = 1 << 30; m_col = rd_sdram_addr[8:0]; end
        CMD_BSTOP:  m_stop = cyc;
        default: ;
      endcase
    end
    if (m_burst && cyc >= m_start + CL && cyc <= m_stop + CL - 1)
      rd_sdram_data = pat(m_ba, m_row, 9'(m_col + 9'(cyc - m_start - CL)));
    else
      rd_sdram_data = 16'hdead;
  end

  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  int act_cyc = -1, act_ba = -1, act_a = -1;
  int rdc_cyc = -1, rdc_ba = -1, rdc_a = -1;
  int bst_cyc = -1, pre_cyc = -1, pre_a = -1, end_cyc = -1;
  int ack_first = -1, ack_cnt = 0, end_total = 0, act_total = 0;

  always @(negedge clk_100M) begin
    case (rd_cmd)
      CMD_ACTIVE: begin
        act_cyc = cyc; act_ba = int'(rd_bank_addr); act_a = int'(rd_sdram_addr);
        ack_cnt = 0; ack_first = -1; bst_cyc = -1; act_total++;
      end
      CMD_READ:      begin rdc_cyc = cyc; rdc_ba = int'(rd_bank_addr); rdc_a = int'(rd_sdram_addr); end
      CMD_BSTOP:     bst_cyc = cyc;
      CMD_PRECHARGE: begin pre_cyc = cyc; pre_a = int'(rd_sdram_addr); end
      default: ;
    endcase
    if (rd_end) begin
      end_cyc = cyc;
      end_total++;
    end
    if (rd_ack) begin
      if (ack_cnt == 0) ack_first = cyc;
      ack_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_data", int'(rd_data), int'(mon_e));
      end
    end
  end

  task automatic push_words(input logic [1:0] ba, input logic [12:0] row, input logic [8:0] col, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(pat(ba, row, 9'(col + 9'(k))));
  endtask

  task automatic wait_end(input int target, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 800 && !done; i++) begin
      @(negedge clk_100M);
      if (end_total >= target) done = 1'b1;
    end
    check(name, int'(done), 1);
  endtask

  task automatic run_access(input logic [1:0] ba, input logic [12:0] row, input logic [8:0] col,
                            input logic [9:0] len, input bit mutate);
    int n, a, r, e0;
    n = int'(eff_burst_len(len));
    push_words(ba, row, col, n);
    @(negedge clk_100M);
    rd_en        = 1'b1;
    rd_addr      = {ba, row, col};
    rd_burst_len = len;
    a  = cyc + 1;
    e0 = end_total;
    @(negedge clk_100M);
    if (mutate) begin
      @(negedge clk_100M);
      rd_addr      = ~rd_addr;
      rd_burst_len = 10'd3;
    end
    rd_en = 1'b0;
    wait_end(e0 + 1, "end_timeout");
    repeat (3) @(negedge clk_100M);
    r = a + T_RCD;
    check("active_cyc", act_cyc, a);
    check("active_ba", act_ba, int'(ba));
    check("active_row", act_a, int'(row));
    check("read_cyc", rdc_cyc, r);
    check("read_ba", rdc_ba, int'(ba));
    check("read_col", rdc_a, int'(col));
    check("bstop_cyc", bst_cyc, r + n);
    check("ack_first", ack_first, r + LAT);
    check("ack_count", ack_cnt, n);
    check("pre_cyc", pre_cyc, r + LAT + n);
    check("pre_a10", pre_a, 'h400);
    check("end_cyc", end_cyc, r + LAT + n + T_RP);
    check("end_count", end_total - e0, 1);
    check("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic hold_test();
    int a, e0, ac0, first_end;
    bit done;
    push_words(2'd3, 13'h0010, 9'd20, 3);
    push_words(2'd3, 13'h0010, 9'd20, 3);
    @(negedge clk_100M);
    rd_en        = 1'b1;
    rd_addr      = {2'd3, 13'h0010, 9'd20};
    rd_burst_len = 10'd3;
    a  = cyc + 1;
    e0 = end_total;
    wait_end(e0 + 1, "hold_end1_timeout");
    first_end = end_cyc;
    check("hold_end1_cyc", first_end, a + T_RCD + LAT + 3 + T_RP);
    ac0  = act_total;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_100M);
      if (act_total > ac0) done = 1'b1;
    end
    rd_en = 1'b0;
    check("hold_act2_seen", int'(done), 1);
    check("hold_act2_cyc", act_cyc, first_end + 2);
    wait_end(e0 + 2, "hold_end2_timeout");
    repeat (3) @(negedge clk_100M);
    check("hold_end_count", end_total - e0, 2);
    check("hold_queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic reset_test();
    int e0;
    bit done;
    push_words(2'd1, 13'h0100, 9'd40, 20);
    @(negedge clk_100M);
    rd_en        = 1'b1;
    rd_addr      = {2'd1, 13'h0100, 9'd40};
    rd_burst_len = 10'd20;
    @(negedge clk_100M);
    rd_en = 1'b0;
    done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_100M);
      if (ack_cnt >= 3) done = 1'b1;
    end
    check("rst_acks_seen", int'(done), 1);
    @(posedge clk_100M);
    #3;
    locked_rst_n = 1'b0;
    #1;
    check("rst_cmd", int'(rd_cmd), int'(CMD_NOP));
    check("rst_ack", int'(rd_ack), 0);
    check("rst_end", int'(rd_end), 0);
    check("rst_ba", int'(rd_bank_addr), 0);
    check("rst_addr", int'(rd_sdram_addr), 0);
`ifdef SDRAM_READ_DQ_REG_EN
    check("rst_data", int'(rd_data), 0);
`endif
    e0 = end_total;
    exp_q.delete();
    repeat (4) @(negedge clk_100M);
    locked_rst_n = 1'b1;
    repeat (30) @(negedge clk_100M);
    check("rst_no_end", end_total - e0, 0);
    check("rst_idle_cmd", int'(rd_cmd), int'(CMD_NOP));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_100M);
    check("reset_cmd", int'(rd_cmd), int'(CMD_NOP));
    check("reset_ba", int'(rd_bank_addr), 0);
    check("reset_addr", int'(rd_sdram_addr), 0);
    check("reset_ack", int'(rd_ack), 0);
    check("reset_end", int'(rd_end), 0);
`ifdef SDRAM_READ_DQ_REG_EN
    check("reset_data", int'(rd_data), 0);
`endif
    locked_rst_n = 1'b1;
    repeat (2) @(negedge clk_100M);

    run_access(2'd0, 13'h0000, 9'd0,   10'd2,    1'b0);
    run_access(2'd2, 13'h0005, 9'd508, 10'd10,   1'b0);
    run_access(2'd1, 13'h1abc, 9'd100, 10'd0,    1'b0);
    run_access(2'd3, 13'h0777, 9'd300, 10'd1023, 1'b0);
    run_access(2'd1, 13'h0042, 9'd510, 10'd5,    1'b1);
    hold_test();
    reset_test();
    run_access(2'd0, 13'h0003, 9'd7,   10'd4,    1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
